// File: rtl/puerto_salida_hs.sv
// Output port: source mux, PROF-deep {port,data} FIFO and
// a four-phase VALIDO/ACK handshake with timeout.
module puerto_salida_hs #(
  parameter int PROF    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       WR_EN,
  input  logic [2:0] SELEC,
  input  logic [2:0] RY,
  input  logic [7:0] RY_DATO,
  input  logic [7:0] INMED,
  input  logic [1:0] PUERTO,
  output logic       LLENO,
  output logic       VACIO,
  output logic [7:0] DATO_OUT,
  output logic [1:0] PUERTO_OUT,
  output logic       VALIDO,
  input  logic       ACK,
  output logic       DESBORDE,
  output logic       ERROR,
  input  logic       CLR_ERR
);

  localparam int PW = $clog2(PROF);
  localparam int CW = $clog2(PROF + 1);
  localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);
  localparam logic [CW-1:0] LLENO_C = CW'(PROF);

  typedef enum logic [1:0] {
    REPOSO,
    ENVIA,
    ESPERA_BAJA
  } estado_t;

  estado_t       estado, estado_sig;
  logic [9:0]    mem [PROF];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] cuenta;
  logic [7:0]    timer;
  logic [7:0]    valor;
  logic          push, pop, fin_tiempo;

  // Source selection for the value being queued
  always_comb begin
    valor = 8'h00;
    case (SELEC)
      3'b001:  valor = {5'b00000, RY};
      3'b010:  valor = RY_DATO;
      3'b011:  valor = INMED;
      default: valor = 8'h00;
    endcase
  end

  assign LLENO = (cuenta == LLENO_C);
  assign VACIO = (cuenta == '0);
  assign push  = WR_EN && !LLENO;

  // Handshake state register
  always_ff @(posedge CLK) begin
    if (RST) estado <= REPOSO;
    else     estado <= estado_sig;
  end

  // Next-state logic
  always_comb begin
    estado_sig = estado;
    case (estado)
      REPOSO:      if (!VACIO) estado_sig = ENVIA;
      ENVIA:       if (ACK) estado_sig = ESPERA_BAJA;
                   else if (timer == TMAX) estado_sig = REPOSO;
      ESPERA_BAJA: if (!ACK) estado_sig = REPOSO;
      default:     estado_sig = REPOSO;
    endcase
  end

  // State-decoded outputs and strobes
  always_comb begin
    VALIDO     = (estado == ENVIA);
    pop        = (estado == REPOSO) && !VACIO;
    fin_tiempo = (estado == ENVIA) && !ACK && (timer == TMAX);
  end

  // FIFO storage; contents need no reset, count gates use
  always_ff @(posedge CLK) begin
    if (push) mem[wptr] <= {PUERTO, valor};
  end

  // Pointers, occupancy count, output holding regs and timer
  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr       <= '0;
      rptr       <= '0;
      cuenta     <= '0;
      DATO_OUT   <= 8'h00;
      PUERTO_OUT <= 2'b00;
      timer      <= 8'h00;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) begin
        rptr       <= rptr + 1'b1;
        DATO_OUT   <= mem[rptr][7:0];
        PUERTO_OUT <= mem[rptr][9:8];
        timer      <= 8'h00;
      end else if (estado == ENVIA && !ACK && !fin_tiempo) begin
        timer <= timer + 8'h01;
      end
      case ({push, pop})
        2'b10:   cuenta <= cuenta + 1'b1;
        2'b01:   cuenta <= cuenta - 1'b1;
        default: cuenta <= cuenta;
      endcase
    end
  end

  // Sticky flags; a set in the clear cycle wins
  always_ff @(posedge CLK) begin
    if (RST) begin
      DESBORDE <= 1'b0;
      ERROR    <= 1'b0;
    end else begin
      if (WR_EN && LLENO) DESBORDE <= 1'b1;
      else if (CLR_ERR)   DESBORDE <= 1'b0;
      if (fin_tiempo)     ERROR <= 1'b1;
      else if (CLR_ERR)   ERROR <= 1'b0;
    end
  end

endmodule

// File: tb/tb_puerto_salida_hs.sv
// Directed bench for puerto_salida_hs with a queue
// scoreboard of expected {port,data} deliveries.
module tb_puerto_salida_hs;

  logic       CLK = 1'b0;
  logic       RST, WR_EN, ACK, CLR_ERR;
  logic [2:0] SELEC, RY;
  logic [7:0] RY_DATO, INMED;
  logic [1:0] PUERTO;
  logic       LLENO, VACIO, VALIDO, DESBORDE, ERROR;
  logic [7:0] DATO_OUT;
  logic [1:0] PUERTO_OUT;

  int errors = 0;
  int checks = 0;
  logic [9:0] q [$];

  puerto_salida_hs #(.PROF(4), .TIMEOUT(8)) dut (
    .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .SELEC(SELEC),
    .RY(RY), .RY_DATO(RY_DATO), .INMED(INMED),
    .PUERTO(PUERTO), .LLENO(LLENO), .VACIO(VACIO),
    .DATO_OUT(DATO_OUT), .PUERTO_OUT(PUERTO_OUT),
    .VALIDO(VALIDO), .ACK(ACK), .DESBORDE(DESBORDE),
    .ERROR(ERROR), .CLR_ERR(CLR_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic wr(input logic [2:0] sel, input logic [2:0] ry,
                    input logic [7:0] dato, input logic [7:0] inm,
                    input logic [1:0] port, input logic [7:0] expv,
                    input bit accept);
    WR_EN = 1'b1; SELEC = sel; RY = ry;
    RY_DATO = dato; INMED = inm; PUERTO = port;
    if (accept) q.push_back({port, expv});
    @(negedge CLK);
    WR_EN = 1'b0;
  endtask

  task automatic expect_valid(input string tag);
    logic [9:0] e;
    int n = 0;
    while (!VALIDO && n < 40) begin
      @(negedge CLK);
      n++;
    end
    chk({tag, "_valido"}, VALIDO, 1'b1);
    if (q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = q.pop_front();
      chk({tag, "_dato"}, DATO_OUT, e[7:0]);
      chk({tag, "_puerto"}, PUERTO_OUT, e[9:8]);
    end
  endtask

  task automatic ack_hs(input string tag);
    ACK = 1'b1;
    @(negedge CLK);
    chk({tag, "_ack_drop"}, VALIDO, 1'b0);
    ACK = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    int n;
    RST = 1'b1; WR_EN = 1'b0; ACK = 1'b0; CLR_ERR = 1'b0;
    SELEC = 3'b000; RY = 3'b000; RY_DATO = 8'h00;
    INMED = 8'h00; PUERTO = 2'b00;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    chk("rst_vacio", VACIO, 1'b1);
    chk("rst_lleno", LLENO, 1'b0);
    chk("rst_valido", VALIDO, 1'b0);
    chk("rst_dato", DATO_OUT, 8'h00);
    chk("rst_puerto", PUERTO_OUT, 2'b00);
    chk("rst_desborde", DESBORDE, 1'b0);
    chk("rst_error", ERROR, 1'b0);

    // Single transfer and latency
    wr(3'b010, 3'b000, 8'hA5, 8'h00, 2'd2, 8'hA5, 1);
    chk("lat_k", VALIDO, 1'b0);
    @(negedge CLK);
    chk("lat_k1", VALIDO, 1'b1);
    expect_valid("t1");
    ack_hs("t1");
    chk("t1_vacio", VACIO, 1'b1);

    // Source mux ordering
    wr(3'b001, 3'b110, 8'hFF, 8'hEE, 2'd1, 8'h06, 1);
    wr(3'b011, 3'b111, 8'hFF, 8'h3C, 2'd3, 8'h3C, 1);
    wr(3'b111, 3'b111, 8'hFF, 8'hEE, 2'd0, 8'h00, 1);
    for (int i = 0; i < 3; i++) begin
      expect_valid("mux");
      ack_hs("mux");
    end
    chk("mux_vacio", VACIO, 1'b1);

    // Fill to full, overflow, drain
    wr(3'b011, 3'b000, 8'h00, 8'h10, 2'd0, 8'h10, 1);
    wr(3'b011, 3'b000, 8'h00, 8'h21, 2'd1, 8'h21, 1);
    wr(3'b011, 3'b000, 8'h00, 8'h32, 2'd2, 8'h32, 1);
    wr(3'b011, 3'b000, 8'h00, 8'h43, 2'd3, 8'h43, 1);
    wr(3'b011, 3'b000, 8'h00, 8'h54, 2'd0, 8'h54, 1);
    chk("full_lleno", LLENO, 1'b1);
    chk("full_nodesb", DESBORDE, 1'b0);
    wr(3'b011, 3'b000, 8'h00, 8'h99, 2'd1, 8'h99, 0);
    chk("ovf_desborde", DESBORDE, 1'b1);
    chk("ovf_lleno", LLENO, 1'b1);
    expect_valid("drain0");
    ack_hs("drain0");
    for (int i = 0; i < 4; i++) begin
      expect_valid("drain");
      ack_hs("drain");
    end
    chk("drain_vacio", VACIO, 1'b1);
    CLR_ERR = 1'b1;
    @(negedge CLK);
    CLR_ERR = 1'b0;
    chk("clr_desborde", DESBORDE, 1'b0);

    // Timeout with no ACK
    wr(3'b011, 3'b000, 8'h00, 8'h11, 2'd1, 8'h11, 1);
    wr(3'b011, 3'b000, 8'h00, 8'h22, 2'd3, 8'h22, 1);
    expect_valid("to_first");
    n = 0;
    while (VALIDO && n < 50) begin
      n++;
      @(negedge CLK);
    end
    chk("to_len", n, 8);
    chk("to_error", ERROR, 1'b1);
    expect_valid("to_next");
    CLR_ERR = 1'b1;
    @(negedge CLK);
    CLR_ERR = 1'b0;
    chk("to_clr", ERROR, 1'b0);
    ack_hs("to_next");

    // Reset mid-handshake
    for (int i = 0; i < 4; i++)
      wr(3'b011, 3'b000, 8'h00, 8'(8'h60 + i), 2'(i),
         8'(8'h60 + i), 1);
    expect_valid("rst_mid");
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    q.delete();
    chk("rmid_valido", VALIDO, 1'b0);
    chk("rmid_vacio", VACIO, 1'b1);
    chk("rmid_dato", DATO_OUT, 8'h00);
    chk("rmid_lleno", LLENO, 1'b0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (VALIDO) n++;
    end
    chk("rmid_quiet", n, 0);

    // ACK held high past VALIDO drop
    wr(3'b010, 3'b000, 8'h7E, 8'h00, 2'd2, 8'h7E, 1);
    wr(3'b010, 3'b000, 8'h81, 8'h00, 2'd1, 8'h81, 1);
    expect_valid("hold1");
    ACK = 1'b1;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      if (VALIDO) n++;
    end
    chk("hold_low", n, 0);
    ACK = 1'b0;
    @(negedge CLK);
    chk("hold_fall", VALIDO, 1'b0);
    @(negedge CLK);
    chk("hold_next", VALIDO, 1'b1);
    expect_valid("hold2");
    ack_hs("hold2");
    chk("end_vacio", VACIO, 1'b1);
    chk("end_sb", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
